// File: rtl/alpqseq.sv
// alpqseq -- Q-register shift sequencer for one 4-bit ALP slice.
//
// Sits directly behind the slice ALU/W-mux. Every cycle it registers the
// inverted (active-high) W result. On start it loads that W result into Q
// and runs a counted shift sequence, left or right, with serial in/out
// pins for cascading to neighbouring slices. While the sequence runs it
// ANDs together the per-cycle W-mux zero indications.
//
// Ports:
//   clk_h         slice clock, rising edge
//   reset_l       synchronous active-low reset
//   wmux_l[3:0]   W-mux result, active-low
//   wmuxz_l       W-mux zero indication, low = result zero
//   start_h       begin sequence (accepted in IDLE only)
//   dir_h         shift direction sampled with start (1 = left)
//   count_h[5:0]  number of shift steps sampled with start
//   abort_h       abandon RUN, back to IDLE with no done pulse
//   q_shl_sin_h   serial in to Q[0] on left shift
//   q_shr_sin_h   serial in to Q[3] on right shift
//   q_shl_sout_h  Q[3]
//   q_shr_sout_h  Q[0]
//   q_h[3:0]      Q register
//   w_h[3:0]      registered W result, active-high
//   busy_h        high in RUN
//   done_h        one-cycle completion pulse
//   zacc_h        accumulated zero flag over the RUN cycles
module alpqseq (
    input  logic       clk_h,
    input  logic       reset_l,
    input  logic [3:0] wmux_l,
    input  logic       wmuxz_l,
    input  logic       start_h,
    input  logic       dir_h,
    input  logic [5:0] count_h,
    input  logic       abort_h,
    input  logic       q_shl_sin_h,
    input  logic       q_shr_sin_h,
    output logic       q_shl_sout_h,
    output logic       q_shr_sout_h,
    output logic [3:0] q_h,
    output logic [3:0] w_h,
    output logic       busy_h,
    output logic       done_h,
    output logic       zacc_h
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] q_reg, q_next;
    logic [3:0] w_reg;
    logic [5:0] cnt_reg, cnt_next;
    logic       dir_reg, dir_next;
    logic       zacc_reg, zacc_next;

    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            state_reg <= IDLE;
            q_reg     <= 4'h0;
            w_reg     <= 4'h0;
            cnt_reg   <= 6'd0;
            dir_reg   <= 1'b0;
            zacc_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            w_reg     <= ~wmux_l;   // free-running W pipeline, every state
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            zacc_reg  <= zacc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        zacc_next  = zacc_reg;
        busy_h     = 1'b0;
        done_h     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start_h) begin
                    // Q is loaded from the live W-mux, not the registered W.
                    q_next     = ~wmux_l;
                    cnt_next   = count_h;
                    dir_next   = dir_h;
                    zacc_next  = 1'b1;
                    state_next = (count_h != 6'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy_h = 1'b1;
                if (abort_h) begin
                    // Abort wins even over the final step: nothing moves.
                    state_next = IDLE;
                end else begin
                    if (dir_reg)
                        q_next = {q_reg[2:0], q_shl_sin_h};
                    else
                        q_next = {q_shr_sin_h, q_reg[3:1]};
                    cnt_next  = cnt_reg - 6'd1;
                    zacc_next = zacc_reg & ~wmuxz_l;
                    // The cnt==1 cycle performs the last shift itself.
                    if (cnt_reg == 6'd1)
                        state_next = DONE;
                end
            end
            DONE: begin
                done_h     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign q_h          = q_reg;
    assign w_h          = w_reg;
    assign zacc_h       = zacc_reg;
    assign q_shl_sout_h = q_reg[3];
    assign q_shr_sout_h = q_reg[0];

endmodule

// File: tb/tb_alpqseq.sv
module tb_alpqseq;

    logic       clk_h = 1'b0;
    logic       reset_l;
    logic [3:0] wmux_l;
    logic       wmuxz_l;
    logic       start_h;
    logic       dir_h;
    logic [5:0] count_h;
    logic       abort_h;
    logic       q_shl_sin_h;
    logic       q_shr_sin_h;
    logic       q_shl_sout_h;
    logic       q_shr_sout_h;
    logic [3:0] q_h;
    logic [3:0] w_h;
    logic       busy_h;
    logic       done_h;
    logic       zacc_h;

    int total = 0;
    int bad   = 0;

    alpqseq dut (
        .clk_h       (clk_h),
        .reset_l     (reset_l),
        .wmux_l      (wmux_l),
        .wmuxz_l     (wmuxz_l),
        .start_h     (start_h),
        .dir_h       (dir_h),
        .count_h     (count_h),
        .abort_h     (abort_h),
        .q_shl_sin_h (q_shl_sin_h),
        .q_shr_sin_h (q_shr_sin_h),
        .q_shl_sout_h(q_shl_sout_h),
        .q_shr_sout_h(q_shr_sout_h),
        .q_h         (q_h),
        .w_h         (w_h),
        .busy_h      (busy_h),
        .done_h      (done_h),
        .zacc_h      (zacc_h)
    );

    always #5 clk_h = ~clk_h;

    typedef struct {
        // inputs applied before the edge
        logic       rst_l;
        logic [3:0] wmux;
        logic       wz_l;
        logic       start;
        logic       dir;
        logic [5:0] count;
        logic       abort;
        logic       shl_sin;
        logic       shr_sin;
        // outputs expected just after the edge
        logic [3:0] e_q;
        logic [3:0] e_w;
        logic       e_busy;
        logic       e_done;
        logic       e_zacc;
        logic       e_shl_so;
        logic       e_shr_so;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mkv(logic rst_l, logic [3:0] wmux, logic wz_l, logic start,
                                 logic dir, logic [5:0] count, logic abort, logic shl_sin,
                                 logic shr_sin, logic [3:0] e_q, logic [3:0] e_w,
                                 logic e_busy, logic e_done, logic e_zacc,
                                 logic e_shl_so, logic e_shr_so);
        vec_t v;
        v.rst_l = rst_l; v.wmux = wmux; v.wz_l = wz_l; v.start = start; v.dir = dir;
        v.count = count; v.abort = abort; v.shl_sin = shl_sin; v.shr_sin = shr_sin;
        v.e_q = e_q; v.e_w = e_w; v.e_busy = e_busy; v.e_done = e_done;
        v.e_zacc = e_zacc; v.e_shl_so = e_shl_so; v.e_shr_so = e_shr_so;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst_l, input logic [3:0] wmux, input logic wz_l,
                         input logic start, input logic dir, input logic [5:0] count,
                         input logic abort, input logic shl_sin, input logic shr_sin);
        reset_l = rst_l; wmux_l = wmux; wmuxz_l = wz_l; start_h = start; dir_h = dir;
        count_h = count; abort_h = abort; q_shl_sin_h = shl_sin; q_shr_sin_h = shr_sin;
    endtask

    task automatic step;
        @(posedge clk_h);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_q, input logic [3:0] e_w,
                           input logic e_busy, input logic e_done, input logic e_zacc,
                           input logic e_shl_so, input logic e_shr_so);
        chk({tag, ".q"},      int'(q_h),          int'(e_q));
        chk({tag, ".w"},      int'(w_h),          int'(e_w));
        chk({tag, ".busy"},   int'(busy_h),       int'(e_busy));
        chk({tag, ".done"},   int'(done_h),       int'(e_done));
        chk({tag, ".zacc"},   int'(zacc_h),       int'(e_zacc));
        chk({tag, ".shlso"},  int'(q_shl_sout_h), int'(e_shl_so));
        chk({tag, ".shrso"},  int'(q_shr_sout_h), int'(e_shr_so));
        $display("%s: q=%h w=%h busy=%b done=%b zacc=%b so=%b%b", tag, q_h, w_h,
                 busy_h, done_h, zacc_h, q_shl_sout_h, q_shr_sout_h);
    endtask

    initial begin
        //               rst wmux  wz st dir cnt ab sl sr   q     w    bsy dn za so so
        vecs[0] = mkv(1'b0, 4'h0, 1, 1, 0, 6'd0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 0); // reset
        vecs[1] = mkv(1'b1, 4'hA, 1, 1, 1, 6'd2, 0, 1, 0, 4'h5, 4'h5, 1, 0, 1, 0, 1); // start left
        vecs[2] = mkv(1'b1, 4'h3, 0, 0, 0, 6'd0, 0, 1, 0, 4'hB, 4'hC, 1, 0, 1, 1, 1);
        vecs[3] = mkv(1'b1, 4'h9, 0, 0, 0, 6'd0, 0, 1, 0, 4'h7, 4'h6, 0, 1, 1, 0, 1); // done
        vecs[4] = mkv(1'b1, 4'hF, 1, 0, 0, 6'd0, 0, 0, 0, 4'h7, 4'h0, 0, 0, 1, 0, 1); // idle
        vecs[5] = mkv(1'b1, 4'h7, 1, 1, 0, 6'd3, 0, 0, 0, 4'h8, 4'h8, 1, 0, 1, 1, 0); // start right
        vecs[6] = mkv(1'b1, 4'hE, 0, 0, 1, 6'd0, 0, 1, 0, 4'h4, 4'h1, 1, 0, 1, 0, 0);
        vecs[7] = mkv(1'b1, 4'h0, 0, 0, 1, 6'd0, 0, 1, 0, 4'h2, 4'hF, 1, 0, 1, 0, 0);
        vecs[8] = mkv(1'b1, 4'h5, 1, 0, 1, 6'd0, 0, 1, 0, 4'h1, 4'hA, 0, 1, 0, 0, 1); // done, zacc 0
        vecs[9] = mkv(1'b1, 4'hF, 1, 0, 0, 6'd0, 0, 0, 0, 4'h1, 4'h0, 0, 0, 0, 0, 1); // idle

        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        #2;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst_l, vecs[i].wmux, vecs[i].wz_l, vecs[i].start, vecs[i].dir,
                  vecs[i].count, vecs[i].abort, vecs[i].shl_sin, vecs[i].shr_sin);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_q, vecs[i].e_w, vecs[i].e_busy,
                    vecs[i].e_done, vecs[i].e_zacc, vecs[i].e_shl_so, vecs[i].e_shr_so);
        end

        // Abort in the second RUN cycle: Q keeps its one-shift value.
        drive(1, 4'hC, 0, 1, 1, 6'd5, 0, 0, 0); step();
        chk_all("abort.start", 4'h3, 4'h3, 1, 0, 1, 0, 1);
        drive(1, 4'hC, 0, 0, 0, 6'd0, 0, 0, 0); step();
        chk_all("abort.run1", 4'h6, 4'h3, 1, 0, 1, 0, 0);
        drive(1, 4'hC, 0, 0, 0, 6'd0, 1, 0, 0); step();
        chk_all("abort.hit", 4'h6, 4'h3, 0, 0, 1, 0, 0);
        drive(1, 4'hC, 0, 0, 0, 6'd0, 1, 0, 0); step();
        chk_all("abort.idle1", 4'h6, 4'h3, 0, 0, 1, 0, 0);
        drive(1, 4'hC, 0, 0, 0, 6'd0, 0, 0, 0); step();
        chk_all("abort.idle2", 4'h6, 4'h3, 0, 0, 1, 0, 0);
        // Restart after abort: right shift one step, zacc cleared by wmuxz_l high.
        drive(1, 4'h6, 1, 1, 0, 6'd1, 0, 0, 1); step();
        chk_all("restart.start", 4'h9, 4'h9, 1, 0, 1, 1, 1);
        drive(1, 4'h6, 1, 0, 0, 6'd0, 0, 0, 1); step();
        chk_all("restart.done", 4'hC, 4'h9, 0, 1, 0, 1, 0);
        drive(1, 4'h6, 1, 0, 0, 6'd0, 0, 0, 0); step();
        chk_all("restart.idle", 4'hC, 4'h9, 0, 0, 0, 1, 0);

        // count 0: straight to DONE; start held through DONE is ignored.
        drive(1, 4'hA, 1, 1, 1, 6'd0, 0, 1, 1); step();
        chk_all("cnt0.start", 4'h5, 4'h5, 0, 1, 1, 0, 1);
        drive(1, 4'h9, 1, 1, 1, 6'd0, 0, 1, 1); step();
        chk_all("cnt0.ign", 4'h5, 4'h6, 0, 0, 1, 0, 1);
        drive(1, 4'h9, 1, 1, 1, 6'd0, 0, 1, 1); step();
        chk_all("cnt0.acc", 4'h6, 4'h6, 0, 1, 1, 0, 0);
        drive(1, 4'hF, 1, 0, 0, 6'd0, 0, 0, 0); step();
        chk_all("cnt0.idle", 4'h6, 4'h0, 0, 0, 1, 0, 0);

        // Reset in the middle of a 10-step left shift.
        drive(1, 4'hE, 0, 1, 1, 6'd10, 0, 1, 0); step();
        chk_all("mrst.start", 4'h1, 4'h1, 1, 0, 1, 0, 1);
        drive(1, 4'hE, 0, 0, 0, 6'd0, 0, 1, 0); step();
        chk_all("mrst.s1", 4'h3, 4'h1, 1, 0, 1, 0, 1);
        step();
        chk_all("mrst.s2", 4'h7, 4'h1, 1, 0, 1, 0, 1);
        step();
        chk_all("mrst.s3", 4'hF, 4'h1, 1, 0, 1, 1, 1);
        drive(0, 4'hE, 0, 1, 1, 6'd3, 1, 1, 0); step();
        chk_all("mrst.rst", 4'h0, 4'h0, 0, 0, 1, 0, 0);
        drive(1, 4'h2, 1, 0, 0, 6'd0, 0, 1, 0); step();
        chk_all("mrst.rel", 4'h0, 4'hD, 0, 0, 1, 0, 0);
        drive(1, 4'h4, 1, 0, 0, 6'd0, 0, 1, 0); step();
        chk_all("mrst.idle", 4'h0, 4'hB, 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
